// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory initiator: RV32I funct3 codes,
// dmemory access sizes, response error codes and the controller state enum.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_FUNCT3   = 2'd2,
    ERR_WINDOW   = 2'd3
  } lsu_err_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Stores only have SB/SH/SW; loads additionally have LBU/LHU.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 <= F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Store data is right-justified; bytes beyond the access size go out as zero.
  function automatic logic [31:0] mask_store(input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] r;
    case (sz)
      SIZE_BYTE: r = {24'd0, d[7:0]};
      SIZE_HALF: r = {16'd0, d[15:0]};
      default:   r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_load_extend.sv
// Combinational sign/zero extension of right-justified dmemory read data.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw_data_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  // Select extension by load type; LW and anything else pass straight through.
  always_comb begin
    result_o = raw_data_i;
    case (funct3_i)
      F3_B:    result_o = {{24{raw_data_i[7]}}, raw_data_i[7:0]};
      F3_H:    result_o = {{16{raw_data_i[15]}}, raw_data_i[15:0]};
      F3_BU:   result_o = {24'd0, raw_data_i[7:0]};
      F3_HU:   result_o = {16'd0, raw_data_i[15:0]};
      default: result_o = raw_data_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: accepts one pipeline request at a time, checks it,
// performs a single-cycle dmemory access and holds the response until taken.
//
// state  | meaning
// IDLE   | ready for a request; checks and latches it on req_valid
// ACCESS | one cycle driving dmemory with the latched request
// RESP   | response presented, held until resp_ready
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h01000000,
  parameter logic [31:0] MEM_BYTES  = 32'h00100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] address,
  output logic        read_write,
  output logic [1:0]  access_size,
  output logic [31:0] data_in,
  input  logic [31:0] data_out
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        store_q, store_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  lsu_err_e    resp_err_q, resp_err_d;

  logic [1:0]  req_size;
  logic        req_misaligned;
  logic        req_in_window;
  lsu_err_e    req_err;
  logic [32:0] addr_ext;
  logic [32:0] win_lo;
  logic [32:0] win_hi;
  logic [31:0] load_data;

  // The window end is formed in 33 bits so a window touching 2^32 or an
  // address near the top of the space can never wrap back into range.
  assign req_size       = req_funct3[1:0];
  assign addr_ext       = {1'b0, req_addr};
  assign win_lo         = {1'b0, START_ADDR};
  assign win_hi         = {1'b0, START_ADDR} + {1'b0, MEM_BYTES};
  assign req_in_window  = (addr_ext >= win_lo) && (addr_ext < win_hi);
  assign req_misaligned = ((req_size == SIZE_HALF) && req_addr[0]) ||
                          ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));

  // Error priority: funct3 first, then alignment, then window.
  always_comb begin
    req_err = ERR_NONE;
    if (!funct3_legal(req_is_store, req_funct3)) req_err = ERR_FUNCT3;
    else if (req_misaligned)                     req_err = ERR_MISALIGN;
    else if (!req_in_window)                     req_err = ERR_WINDOW;
  end

  load_extend u_load_extend (
    .raw_data_i (data_out),
    .funct3_i   (funct3_q),
    .result_o   (load_data)
  );

  // Next-state, latch and dmemory/handshake output decode.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    store_d      = store_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    read_write   = 1'b0;
    address      = START_ADDR;
    access_size  = SIZE_WORD;
    data_in      = 32'd0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          funct3_d     = req_funct3;
          store_d      = req_is_store;
          resp_rdata_d = 32'd0;
          resp_err_d   = req_err;
          state_d      = (req_err == ERR_NONE) ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        address      = addr_q;
        access_size  = funct3_q[1:0];
        read_write   = store_q;
        data_in      = mask_store(wdata_q, funct3_q[1:0]);
        resp_rdata_d = store_q ? 32'd0 : load_data;
        state_d      = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset is synchronous, but a store caught in ACCESS must not write in
    // the reset cycle itself, and an abandoned transaction shows no handshake.
    if (reset) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      read_write = 1'b0;
    end
  end

  // State and request/response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      funct3_q     <= 3'd0;
      store_q      <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      store_q      <= store_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: the driver pushes expected
// responses and writes from a byte-level reference model; a negedge monitor
// pops and compares whatever the DUT presents.
module tb_lsu_mem_initiator;

  localparam bit [31:0] START = 32'h01000000;
  localparam bit [31:0] MEMB  = 32'h00100000;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] address;
  logic        read_write;
  logic [1:0]  access_size;
  logic [31:0] data_in;
  logic [31:0] data_out;

  lsu_mem_initiator #(.START_ADDR(START), .MEM_BYTES(MEMB)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .address      (address),
    .read_write   (read_write),
    .access_size  (access_size),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
  } wr_t;

  exp_t      exp_q[$];
  wr_t       wr_q[$];
  bit [7:0]  ref_mem[bit [31:0]];
  bit [7:0]  env_mem[bit [31:0]];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ready_mode = 0;   // 0 random, 1 hold low, 2 hold high
  bit pending  = 0;
  logic [31:0] held_rdata;
  logic [1:0]  held_err;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event (cycle %0d)", nm, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic bit [7:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic int model_err(input bit st, input bit [2:0] f3, input bit [31:0] a);
    int nb;
    if (st) begin
      if (f3 > 2) return 2;
    end else if (!(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) begin
      return 2;
    end
    nb = 1 << (f3 % 4);
    if ((a % nb) != 0) return 1;
    if (longint'(a) < longint'(START) || longint'(a) >= longint'(START) + longint'(MEMB)) return 3;
    return 0;
  endfunction

  function automatic bit [31:0] model_load(input bit [2:0] f3, input bit [31:0] a);
    longint v = 0;
    int nb = 1 << (f3 % 4);
    for (int i = nb - 1; i >= 0; i--) v = v * 256 + longint'(ref_rd(a + i));
    if (f3 < 4 && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic model_accept(input bit st, input bit [2:0] f3, input bit [31:0] a,
                              input bit [31:0] wd, input int c);
    exp_t e;
    wr_t  w;
    int   nb;
    int   er;
    er      = model_err(st, f3, a);
    e.err   = er[1:0];
    e.due   = c + ((er == 0) ? 2 : 1);
    e.rdata = (er == 0 && !st) ? model_load(f3, a) : 32'd0;
    if (er == 0 && st) begin
      nb = 1 << (f3 % 4);
      for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
      w.addr = a;
      w.size = f3[1:0];
      w.data = (nb == 4) ? wd : (wd & ((32'd1 << (8 * nb)) - 32'd1));
      wr_q.push_back(w);
    end
    exp_q.push_back(e);
  endtask

  // ---------------- dmemory environment ----------------
  function automatic logic [31:0] env_read(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] v = 32'd0;
    int nb = 1 << sz;
    for (int i = 0; i < nb && i < 4; i++)
      v[8*i +: 8] = env_mem.exists(a + i) ? env_mem[a + i] : 8'h00;
    return v;
  endfunction

  initial data_out = 32'd0;

  // Monitor: checks writes, idle defaults and responses; also acts as dmemory.
  always @(negedge clk) begin
    wr_t  w;
    exp_t e;
    if (read_write) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", {31'd0, read_write}, 32'd0);
      end else begin
        w = wr_q.pop_front();
        check("write_addr", address, w.addr);
        check("write_size", {30'd0, access_size}, {30'd0, w.size});
        check("write_data", data_in, w.data);
      end
      for (int i = 0; i < (1 << access_size) && i < 4; i++)
        env_mem[address + i] = data_in[8*i +: 8];
    end
    if (reset) begin
      pending = 0;
    end else begin
      if (req_ready || resp_valid) begin
        check("idle_address", address, START);
        check("idle_size", {30'd0, access_size}, 32'd2);
        check("idle_data_in", data_in, 32'd0);
        check("idle_read_write", {31'd0, read_write}, 32'd0);
      end
      if (resp_valid) begin
        check("ready_in_resp", {31'd0, req_ready}, 32'd0);
        if (!pending) begin
          if (exp_q.size() == 0) begin
            check("unexpected_resp", {31'd0, resp_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", {30'd0, resp_err}, {30'd0, e.err});
            check("resp_latency", cyc, e.due);
          end
          held_rdata = resp_rdata;
          held_err   = resp_err;
          pending    = 1;
        end else begin
          check("hold_rdata", resp_rdata, held_rdata);
          check("hold_err", {30'd0, resp_err}, {30'd0, held_err});
        end
        if (resp_ready) pending = 0;
      end
    end
    data_out = env_read(address, access_size);
  end

  // resp_ready driver
  initial begin
    resp_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1)      resp_ready = 0;
      else if (ready_mode == 2) resp_ready = 1;
      else                      resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input bit st, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input bit track, output int acc);
    int n = 0;
    acc          = -1;
    req_valid    = 1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    forever begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        if (track) model_accept(st, f3, a, wd, cyc);
        break;
      end
      n++;
      if (n > 40) begin
        fail_now("accept_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int a0, a1, a2, tmo;
  bit [2:0] ld_codes[5];
  bit [31:0] ra;
  bit [2:0]  rf;
  bit        rs;

  initial begin
    ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    reset = 1; req_valid = 0; req_is_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_read_write", {31'd0, read_write}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {30'd0, resp_err}, 32'd0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // store then load
    issue(1, 3'b010, 32'h01000000, 32'h00005554, 1, a0);
    issue(0, 3'b010, 32'h01000000, 32'h0, 1, a0);
    // sign / zero extension
    issue(1, 3'b000, 32'h01000003, 32'hABCDEF80, 1, a0);
    issue(0, 3'b000, 32'h01000003, 32'h0, 1, a0);
    issue(0, 3'b100, 32'h01000003, 32'h0, 1, a0);
    issue(1, 3'b001, 32'h01000010, 32'h1234F00D, 1, a0);
    issue(0, 3'b001, 32'h01000010, 32'h0, 1, a0);
    issue(0, 3'b101, 32'h01000010, 32'h0, 1, a0);
    // misaligned
    issue(0, 3'b010, 32'h01000002, 32'h0, 1, a0);
    issue(1, 3'b001, 32'h01000001, 32'hFFFFFFFF, 1, a0);
    // illegal funct3, window boundaries, priorities
    issue(0, 3'b011, 32'h01000000, 32'h0, 1, a0);
    issue(1, 3'b011, 32'h01000000, 32'h1, 1, a0);
    issue(0, 3'b111, 32'h01000001, 32'h0, 1, a0);
    issue(0, 3'b010, 32'h00FFFFFC, 32'h0, 1, a0);
    issue(0, 3'b010, 32'h00FFFFFE, 32'h0, 1, a0);
    issue(0, 3'b010, 32'hFFFFFFFC, 32'h0, 1, a0);
    issue(1, 3'b010, START + MEMB - 4, 32'hCAFEBABE, 1, a0);
    issue(0, 3'b010, START + MEMB - 4, 32'h0, 1, a0);
    issue(0, 3'b010, START + MEMB, 32'h0, 1, a0);

    // backpressure: hold resp_ready low for 5 cycles of resp_valid
    ready_mode = 1;
    issue(0, 3'b010, 32'h01000000, 32'h0, 1, a0);
    tmo = 0;
    forever begin
      @(negedge clk);
      if (resp_valid) break;
      tmo++;
      if (tmo > 20) begin
        fail_now("stall_resp_timeout");
        break;
      end
    end
    repeat (5) @(negedge clk);
    ready_mode = 2;
    idle(3);

    // back-to-back throughput with resp_ready high
    issue(0, 3'b010, 32'h01000000, 32'h0, 1, a0);
    issue(0, 3'b000, 32'h01000003, 32'h0, 1, a1);
    issue(0, 3'b100, 32'h01000003, 32'h0, 1, a2);
    check("throughput_1", a1 - a0, 32'd3);
    check("throughput_2", a2 - a1, 32'd3);
    ready_mode = 0;

    // reset during a store's ACCESS cycle: no write, no response
    issue(1, 3'b010, 32'h01000000, 32'hDEADBEEF, 0, a0);
    reset = 1;
    @(negedge clk);
    check("rst_access_read_write", {31'd0, read_write}, 32'd0);
    check("rst_access_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    issue(0, 3'b010, 32'h01000000, 32'h0, 1, a0);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      rs = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) rf = 3'($urandom_range(0, 7));
      else if (rs)                   rf = 3'($urandom_range(0, 2));
      else                           rf = ld_codes[$urandom_range(0, 4)];
      case ($urandom_range(0, 9))
        0:       ra = START - 8 + $urandom_range(0, 11);
        1:       ra = START + MEMB - 8 + $urandom_range(0, 11);
        2:       ra = 32'hFFFFFFF4 + $urandom_range(0, 11);
        default: ra = START + $urandom_range(0, 31);
      endcase
      issue(rs, rf, ra, $urandom, 1, a0);
      idle($urandom_range(0, 2));
    end

    ready_mode = 2;
    tmo = 0;
    while (exp_q.size() != 0 || wr_q.size() != 0) begin
      @(negedge clk);
      tmo++;
      if (tmo > 50) begin
        fail_now("drain_timeout");
        break;
      end
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
